// File: rtl/rf_wport_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the register-file address/data widths, the register-zero constant,
// the grant-source encoding and a small hazard-compare helper.
package rf_wport_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GRANT_IDLE   = 2'd0,
    GRANT_WB     = 2'd1,
    GRANT_QUEUE  = 2'd2,
    GRANT_BYPASS = 2'd3
  } grant_e;

  // A pending destination matches a read port only for a real register;
  // r0 is hard-wired and can never carry a hazard.
  function automatic logic rd_hit(input logic [RF_ADDR_W-1:0] dst,
                                  input logic [RF_ADDR_W-1:0] rd);
    return (dst == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_wq.sv
// In-order mul/div result queue.
// Each slot carries a valid bit that a writeback to the same destination can
// clear (WAW kill); a killed slot keeps its place and still pops in order.
// Ports:
//   clock, rst                 clock, synchronous active-high reset
//   i_push/i_push_addr/_data   enqueue a result (ignored when full)
//   i_pop                      drop the head slot (ignored when empty)
//   i_kill_en/i_kill_addr      clear valid on every slot whose addr matches
//   o_full, o_empty            occupancy flags
//   o_head_valid/_addr/_data   current head slot (valid gated by !empty)
//   o_ent_valid, o_ent_addr    all slots in parallel, for the hazard compare
module rf_wq
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              rst,
  input  logic                              i_push,
  input  logic [RF_ADDR_W-1:0]              i_push_addr,
  input  logic [RF_DATA_W-1:0]              i_push_data,
  input  logic                              i_pop,
  input  logic                              i_kill_en,
  input  logic [RF_ADDR_W-1:0]              i_kill_addr,
  output logic                              o_full,
  output logic                              o_empty,
  output logic                              o_head_valid,
  output logic [RF_ADDR_W-1:0]              o_head_addr,
  output logic [RF_DATA_W-1:0]              o_head_data,
  output logic [DEPTH-1:0]                  o_ent_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]   o_ent_addr
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]          r_wr_ptr;
  logic [PW:0]          r_rd_ptr;
  logic [DEPTH-1:0]     r_valid;
  logic [RF_ADDR_W-1:0] r_addr [DEPTH];
  logic [RF_DATA_W-1:0] r_data [DEPTH];

  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_wr_idx  = r_wr_ptr[PW-1:0];
  assign w_rd_idx  = r_rd_ptr[PW-1:0];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (w_wr_idx == w_rd_idx);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_head_valid = !o_empty && r_valid[w_rd_idx];
  assign o_head_addr  = r_addr[w_rd_idx];
  assign o_head_data  = r_data[w_rd_idx];
  assign o_ent_valid  = r_valid;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign o_ent_addr[gi] = r_addr[gi];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Push and pop can never target the same slot (that would need the queue
  // to be both full and empty), so the priority below only orders kill.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push_ok && (w_wr_idx == PW'(i))) begin
          r_valid[i] <= 1'b1;
        end else if (w_pop_ok && (w_rd_idx == PW'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (i_kill_en && (r_addr[i] == i_kill_addr)) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_addr[w_wr_idx] <= i_push_addr;
      r_data[w_wr_idx] <= i_push_data;
    end
  end

endmodule

// File: rtl/rf_wport_arb.sv
// Write-port arbiter and scoreboard for the general register file.
// Shares the single write port between the writeback stage (priority) and
// the mul/div unit, whose results are queued in order in rf_wq. Tracks
// pending mul/div destinations for decode hazard stalls and asks for a
// writeback bubble when queued results have been starved too long.
// Ports:
//   clock, rst                 clock, synchronous active-high reset
//   pause                      pipeline pause: no pop, no bypass
//   wb_wren/wb_addr/wb_data    writeback write request
//   md_valid/md_addr/md_data   mul/div result, md_ready = queue not full
//   rd_addr_a/rd_addr_b        decode read addresses; hz_stall on a hit
//   drain_req                  starvation bubble request
//   rf_data/rf_wraddress/rf_wren  register-file write inputs (combinational)
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 pause,
  input  logic                 wb_wren,
  input  logic [RF_ADDR_W-1:0] wb_addr,
  input  logic [RF_DATA_W-1:0] wb_data,
  input  logic                 md_valid,
  input  logic [RF_ADDR_W-1:0] md_addr,
  input  logic [RF_DATA_W-1:0] md_data,
  output logic                 md_ready,
  input  logic [RF_ADDR_W-1:0] rd_addr_a,
  input  logic [RF_ADDR_W-1:0] rd_addr_b,
  output logic                 hz_stall,
  output logic                 drain_req,
  output logic [RF_DATA_W-1:0] rf_data,
  output logic [RF_ADDR_W-1:0] rf_wraddress,
  output logic                 rf_wren
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]        r_starve_cnt;
  logic [RF_ADDR_W-1:0] r_last_addr;
  logic [RF_DATA_W-1:0] r_last_data;

  grant_e                            w_grant;
  logic                              w_wb_win;
  logic                              w_push;
  logic                              w_pop;
  logic                              w_q_full;
  logic                              w_q_empty;
  logic                              w_head_valid;
  logic [RF_ADDR_W-1:0]              w_head_addr;
  logic [RF_DATA_W-1:0]              w_head_data;
  logic [DEPTH-1:0]                  w_ent_valid;
  logic [DEPTH-1:0][RF_ADDR_W-1:0]   w_ent_addr;
  logic                              w_hz;

  rf_wq #(
    .DEPTH (DEPTH)
  ) u_wq (
    .clock        (clock),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_addr  (md_addr),
    .i_push_data  (md_data),
    .i_pop        (w_pop),
    .i_kill_en    (w_wb_win),
    .i_kill_addr  (wb_addr),
    .o_full       (w_q_full),
    .o_empty      (w_q_empty),
    .o_head_valid (w_head_valid),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_ent_valid  (w_ent_valid),
    .o_ent_addr   (w_ent_addr)
  );

  assign w_wb_win = wb_wren && (wb_addr != REG_ZERO);
  assign md_ready = !rst && !w_q_full;

  always_comb begin
    w_grant = GRANT_IDLE;
    if (rst) begin
      w_grant = GRANT_IDLE;
    end else if (w_wb_win) begin
      w_grant = GRANT_WB;
    end else if (!pause && !w_q_empty) begin
      w_grant = GRANT_QUEUE;
    end else if (!pause && md_valid) begin
      w_grant = GRANT_BYPASS;
    end
  end

  // A bypassed result (including a discarded r0 result) never enters the
  // queue; r0 results are accepted but dropped on every path.
  assign w_pop  = (w_grant == GRANT_QUEUE);
  assign w_push = md_valid && md_ready && (w_grant != GRANT_BYPASS) &&
                  (md_addr != REG_ZERO);

  always_comb begin
    rf_wren      = 1'b0;
    rf_wraddress = r_last_addr;
    rf_data      = r_last_data;
    case (w_grant)
      GRANT_WB: begin
        rf_wren      = 1'b1;
        rf_wraddress = wb_addr;
        rf_data      = wb_data;
      end
      GRANT_QUEUE: begin
        // A killed head still pops, but writes nothing.
        if (w_head_valid) begin
          rf_wren      = 1'b1;
          rf_wraddress = w_head_addr;
          rf_data      = w_head_data;
        end
      end
      GRANT_BYPASS: begin
        if (md_addr != REG_ZERO) begin
          rf_wren      = 1'b1;
          rf_wraddress = md_addr;
          rf_data      = md_data;
        end
      end
      default: begin
        rf_wren = 1'b0;
      end
    endcase
    if (rst) begin
      rf_wraddress = '0;
      rf_data      = '0;
    end
  end

  // Hazard: any live queued destination, plus the incoming result whenever
  // it is not being written straight through this cycle.
  always_comb begin
    w_hz = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] &&
          (rd_hit(w_ent_addr[i], rd_addr_a) || rd_hit(w_ent_addr[i], rd_addr_b))) begin
        w_hz = 1'b1;
      end
    end
    if (md_valid && (w_grant != GRANT_BYPASS) &&
        (rd_hit(md_addr, rd_addr_a) || rd_hit(md_addr, rd_addr_b))) begin
      w_hz = 1'b1;
    end
  end

  assign hz_stall  = !rst && w_hz;
  assign drain_req = !rst && (r_starve_cnt == CW'(STARVE_MAX));

  always_ff @(posedge clock) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_pop || w_q_empty) begin
      r_starve_cnt <= '0;
    end else if (w_wb_win && (r_starve_cnt != CW'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Idle cycles replay the last written address/data.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (rf_wren) begin
      r_last_addr <= rf_wraddress;
      r_last_data <= rf_data;
    end
  end

endmodule
